// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit combinational cell, d = a - b - bin with borrow out
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in), d (difference bit), bout (borrow out)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock, valid/ready on both sides
// Ports: clk, rst (sync active-high); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with results diff, borrow_out, overflow
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_bor, r_a_msb, r_b_msb, r_bout, r_ovf;
    logic             w_d, w_bout, w_last;

    full_subtractor u_cell (
        .a   (r_a[0]),
        .b   (r_b[0]),
        .bin (r_bor),
        .d   (w_d),
        .bout(w_bout)
    );

    assign w_last     = r_cnt == CW'(WIDTH - 1);
    assign in_ready   = r_state == IDLE;
    assign out_valid  = r_state == DONE;
    assign diff       = r_diff;
    assign borrow_out = r_bout;
    assign overflow   = r_ovf;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? BUSY : IDLE;
            BUSY:    w_next = w_last ? DONE : BUSY;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // r_a doubles as the result register: difference bits enter at the MSB
    // as minuend bits leave at the LSB, so after WIDTH shifts it holds a - b.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_bor   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_a     <= a;
                r_b     <= b;
                r_bor   <= 1'b0;
                r_cnt   <= '0;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (r_state == BUSY) begin
                r_a   <= {w_d, r_a[WIDTH-1:1]};
                r_b   <= r_b >> 1;
                r_bor <= w_bout;
                if (!w_last) r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_diff <= {w_d, r_a[WIDTH-1:1]};
                    r_bout <= w_bout;
                    r_ovf  <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic       iv8, ir8, ov8, or8, bo8, of8;
    logic [7:0] a8, b8, d8;
    logic       iv4, ir4, ov4, or4, bo4, of4;
    logic [3:0] a4, b4, d4;
    logic       fa, fb, fbin, fd, fbout;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8), .overflow(of8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow_out(bo4), .overflow(of4)
    );

    full_subtractor fs (.a(fa), .b(fb), .bin(fbin), .d(fd), .bout(fbout));

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input int a, input int b,
                                  output int d, output int br, output int ov);
        int sa, sb, r;
        d  = (a - b) & ((1 << w) - 1);
        br = int'(a < b);
        sa = a >= (1 << (w - 1)) ? a - (1 << w) : a;
        sb = b >= (1 << (w - 1)) ? b - (1 << w) : b;
        r  = sa - sb;
        ov = int'(r > (1 << (w - 1)) - 1 || r < -(1 << (w - 1)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (!ir8 && n < 50) begin
            step();
            n++;
        end
        check("ready8", int'(ir8), 1);
    endtask

    task automatic op8(input int a, input int b, input int hold, input bit glitch);
        int n, ed, eb, eo;
        model(8, a, b, ed, eb, eo);
        wait_ready8();
        a8 = 8'(a);
        b8 = 8'(b);
        iv8 = 1'b1;
        or8 = (hold == 0);
        step();
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 20) begin
            if (glitch && n == 2) begin
                iv8 = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end else iv8 = 1'b0;
            step();
            n++;
        end
        iv8 = 1'b0;
        check("lat8", n, 8);
        check("diff8", int'(d8), ed);
        check("bor8", int'(bo8), eb);
        check("ovf8", int'(of8), eo);
        repeat (hold) begin
            step();
            check("hold_valid", int'(ov8), 1);
            check("hold_rdy", int'(ir8), 0);
            check("hold_diff", int'(d8), ed);
            check("hold_bor", int'(bo8), eb);
            check("hold_ovf", int'(of8), eo);
        end
        or8 = 1'b1;
        step();
        check("rdy_after", int'(ir8), 1);
        check("valid_after", int'(ov8), 0);
    endtask

    task automatic op4(input int a, input int b);
        int n, ed, eb, eo;
        model(4, a, b, ed, eb, eo);
        n = 0;
        while (!ir4 && n < 50) begin
            step();
            n++;
        end
        check("ready4", int'(ir4), 1);
        a4 = 4'(a);
        b4 = 4'(b);
        iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 20) begin
            step();
            n++;
        end
        check("lat4", n, 4);
        check("diff4", int'(d4), ed);
        check("bor4", int'(bo4), eb);
        check("ovf4", int'(of4), eo);
        step();
    endtask

    initial begin
        rst = 1'b1;
        {iv8, or8, a8, b8} = '0;
        {iv4, a4, b4} = '0;
        or4 = 1'b1;
        {fa, fb, fbin} = '0;
        step();
        step();
        check("rst_ready", int'(ir8), 1);
        check("rst_valid", int'(ov8), 0);
        check("rst_diff", int'(d8), 0);
        check("rst_bor", int'(bo8), 0);
        check("rst_ovf", int'(of8), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            int r;
            {fa, fb, fbin} = 3'(i);
            #1;
            r = int'(fa) - int'(fb) - int'(fbin);
            check("fs_d", int'(fd), r & 1);
            check("fs_bout", int'(fbout), int'(r < 0));
        end

        op8(8'h05, 8'h03, 0, 1'b0);
        op8(8'h03, 8'h05, 0, 1'b0);
        op8(8'h80, 8'h01, 0, 1'b0);
        op8(8'h00, 8'h00, 5, 1'b0);
        op8(8'h12, 8'h34, 0, 1'b1);
        op8(8'hFF, 8'hFF, 0, 1'b0);
        op8(8'h00, 8'hFF, 0, 1'b0);

        wait_ready8();
        a8 = 8'h12;
        b8 = 8'h34;
        iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", int'(ir8), 1);
        check("mid_rst_valid", int'(ov8), 0);
        check("mid_rst_diff", int'(d8), 0);
        check("mid_rst_bor", int'(bo8), 0);
        check("mid_rst_ovf", int'(of8), 0);
        op8(8'h10, 8'h01, 0, 1'b0);

        repeat (20) op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 2)), 1'($urandom));

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op4(a, b);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
